// File: rtl/nv_nvdla_ssyncnd_c_pkg.sv
// Shared constants for the nv_nvdla_ssyncnd_c level synchroniser.
// Holds the legal parameter ranges, the default reset value and the
// per-channel output record used by nv_nvdla_ssync_filt.
// Optional feature macro: NVDLA_SSYNC_FILTER_EN (glitch filter counters).
package nv_nvdla_ssyncnd_c_pkg;

   // Legal parameter ranges.
   localparam int WIDTH_MIN  = 1;
   localparam int WIDTH_MAX  = 32;
   localparam int DEPTH_MIN  = 2;
   localparam int DEPTH_MAX  = 4;
   localparam int FILT_W_MIN = 1;
   localparam int FILT_W_MAX = 8;

   // Default per-channel reset value, sliced down to WIDTH by the top.
   localparam logic [WIDTH_MAX-1:0] RESET_VAL_DEFAULT = '0;

   // Registered per-channel output: filtered level plus its edge pulses.
   typedef struct packed {
      logic level;
      logic rise;
      logic fall;
   } edge_t;

   // Keeps an out-of-range parameter inside the supported window so the
   // chain never degenerates to fewer than two metastability stages.
   function automatic int clamp_int(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

endpackage

// File: rtl/nv_nvdla_ssyncnd_c_filt.sv
// Per-channel glitch filter and edge detector (module nv_nvdla_ssync_filt).
// With NVDLA_SSYNC_FILTER_EN defined, the filtered level only follows the
// synchronised input q after it has disagreed for thr+1 consecutive edges.
// Without it, the level follows q every edge and thr is unused.
// Edge pulses are registered and coincide with the level update.
module nv_nvdla_ssync_filt
   import nv_nvdla_ssyncnd_c_pkg::*;
#(
   parameter int   FILT_W    = 3,
   parameter logic RESET_BIT = 1'b0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              q,
   input  logic [FILT_W-1:0] thr,
   output logic              level,
   output logic              rise,
   output logic              fall
);

   edge_t st_q;
   edge_t st_d;
   logic  take;

`ifdef NVDLA_SSYNC_FILTER_EN
   logic [FILT_W-1:0] cnt_q;
   logic [FILT_W-1:0] cnt_d;

   // Count consecutive disagreements; accept q once the count reaches thr.
   // thr is compared live, so lowering it takes effect on the next edge.
   always_comb begin
      take  = 1'b0;
      cnt_d = cnt_q;
      if (q == st_q.level) begin
         cnt_d = '0;
      end else if (cnt_q >= thr) begin
         take  = 1'b1;
         cnt_d = '0;
      end else if (cnt_q != {FILT_W{1'b1}}) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register; reset discards any partial count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
`else
   logic thr_unused;

   // No filtering: any difference is accepted on the next edge.
   always_comb begin
      take = (q != st_q.level);
   end

   assign thr_unused = ^thr;
`endif

   // Next level and the one-cycle pulses that accompany a level change.
   always_comb begin
      st_d.level = take ? q : st_q.level;
      st_d.rise  = take & q;
      st_d.fall  = take & ~q;
   end

   // Output register; reset forces the level to its reset bit, no pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q <= '{level: RESET_BIT, rise: 1'b0, fall: 1'b0};
      end else begin
         st_q <= st_d;
      end
   end

   assign level = st_q.level;
   assign rise  = st_q.rise;
   assign fall  = st_q.fall;

endmodule

// File: rtl/nv_nvdla_ssyncnd_c.sv
// nv_nvdla_ssyncnd_c: WIDTH-channel level synchroniser with optional
// glitch filter and registered rise/fall pulses.
// Each channel: DEPTH-stage synchroniser chain -> nv_nvdla_ssync_filt.
// Optional feature macro: NVDLA_SSYNC_FILTER_EN (enables filt_thr counters).
module nv_nvdla_ssyncnd_c
   import nv_nvdla_ssyncnd_c_pkg::*;
#(
   parameter int               WIDTH     = 4,
   parameter int               DEPTH     = 3,
   parameter int               FILT_W    = 3,
   parameter logic [WIDTH-1:0] RESET_VAL = RESET_VAL_DEFAULT[WIDTH-1:0]
) (
   input  logic              o_clk,
   input  logic              o_rst,
   input  logic [WIDTH-1:0]  sync_i,
   input  logic [FILT_W-1:0] filt_thr,
   output logic [WIDTH-1:0]  sync_o,
   output logic [WIDTH-1:0]  rise_o,
   output logic [WIDTH-1:0]  fall_o
);

   localparam int DEPTH_C = clamp_int(DEPTH, DEPTH_MIN, DEPTH_MAX);

   logic [WIDTH-1:0] q;

   // Synchroniser chain: one named flop bank per stage, holding nothing but
   // the sampled levels so CDC tools see a clean multi-flop synchroniser.
   for (genvar k = 0; k < DEPTH_C; k++) begin : g_stage
      logic [WIDTH-1:0] stage_q;
      if (k == 0) begin : g_first
         // First stage samples the asynchronous inputs.
         always_ff @(posedge o_clk or posedge o_rst) begin
            if (o_rst) begin
               stage_q <= RESET_VAL;
            end else begin
               stage_q <= sync_i;
            end
         end
      end else begin : g_next
         // Later stages resolve metastability of the previous stage.
         always_ff @(posedge o_clk or posedge o_rst) begin
            if (o_rst) begin
               stage_q <= RESET_VAL;
            end else begin
               stage_q <= g_stage[k-1].stage_q;
            end
         end
      end
   end

   assign q = g_stage[DEPTH_C-1].stage_q;

   // Independent filter and edge logic per channel.
   for (genvar c = 0; c < WIDTH; c++) begin : g_chan
      nv_nvdla_ssync_filt #(
         .FILT_W    (FILT_W),
         .RESET_BIT (RESET_VAL[c])
      ) u_filt (
         .clk   (o_clk),
         .rst   (o_rst),
         .q     (q[c]),
         .thr   (filt_thr),
         .level (sync_o[c]),
         .rise  (rise_o[c]),
         .fall  (fall_o[c])
      );
   end

endmodule

// File: tb/tb_nv_nvdla_ssyncnd_c.sv
// Self-checking bench for nv_nvdla_ssyncnd_c (WIDTH=4, DEPTH=3, FILT_W=3,
// RESET_VAL=4'hA). Expected outputs come from a delay-line plus
// disagreement-run reference model; NVDLA_SSYNC_FILTER_EN selects whether
// the model applies the threshold.
module tb_nv_nvdla_ssyncnd_c;

   localparam int W  = 4;
   localparam int D  = 3;
   localparam int FW = 3;
   localparam logic [W-1:0] RV = 4'hA;
`ifdef NVDLA_SSYNC_FILTER_EN
   localparam bit FILT_ON = 1'b1;
`else
   localparam bit FILT_ON = 1'b0;
`endif

   logic          o_clk = 1'b0;
   logic          o_rst;
   logic [W-1:0]  sync_i;
   logic [FW-1:0] filt_thr;
   logic [W-1:0]  sync_o;
   logic [W-1:0]  rise_o;
   logic [W-1:0]  fall_o;

   int total = 0;
   int bad   = 0;

   // Outputs are valid every clock while out of reset: one expected entry
   // {sync_o, rise_o, fall_o} is pushed per issued edge and popped per edge.
   logic [3*W-1:0] exp_q[$];

   // Reference model state.
   logic [W-1:0] pipe[$];
   logic [W-1:0] m_out;
   int           run[W];

   nv_nvdla_ssyncnd_c #(
      .WIDTH     (W),
      .DEPTH     (D),
      .FILT_W    (FW),
      .RESET_VAL (RV)
   ) dut (
      .o_clk    (o_clk),
      .o_rst    (o_rst),
      .sync_i   (sync_i),
      .filt_thr (filt_thr),
      .sync_o   (sync_o),
      .rise_o   (rise_o),
      .fall_o   (fall_o)
   );

   // Clock.
   always #5 o_clk = ~o_clk;

   // Watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int eff_t();
      return FILT_ON ? int'(filt_thr) : 0;
   endfunction

   task automatic model_reset();
      pipe.delete();
      for (int i = 0; i < D; i++) pipe.push_back(RV);
      m_out = RV;
      for (int c = 0; c < W; c++) run[c] = 0;
   endtask

   // One clock edge of the reference: the level seen by the filter is the
   // input sampled D edges earlier; a channel adopts it once it has
   // disagreed with the output for t+1 consecutive edges.
   task automatic model_edge(input logic [W-1:0] din, input int t);
      logic [W-1:0] qv;
      logic [W-1:0] r;
      logic [W-1:0] f;
      qv = pipe[D-1];
      r  = '0;
      f  = '0;
      for (int c = 0; c < W; c++) begin
         if (qv[c] == m_out[c]) begin
            run[c] = 0;
         end else begin
            run[c] = run[c] + 1;
            if (run[c] >= t + 1) begin
               m_out[c] = qv[c];
               r[c]     = qv[c];
               f[c]     = ~qv[c];
               run[c]   = 0;
            end
         end
      end
      pipe.push_front(din);
      void'(pipe.pop_back());
      exp_q.push_back({m_out, r, f});
   endtask

   // Driver: called at a negedge, returns at the next negedge.
   task automatic step(input logic [W-1:0] v);
      sync_i = v;
      model_edge(v, eff_t());
      @(negedge o_clk);
   endtask

   task automatic hold(input logic [W-1:0] v, input int n);
      for (int i = 0; i < n; i++) step(v);
   endtask

   task automatic do_reset();
      o_rst = 1'b1;
      #1;
      check("rst_sync_o", 32'(sync_o), 32'(RV));
      check("rst_rise_o", 32'(rise_o), 32'h0);
      check("rst_fall_o", 32'(fall_o), 32'h0);
      @(negedge o_clk);
      o_rst = 1'b0;
      model_reset();
   endtask

   // Monitor: compares every presented output against the scoreboard.
   always @(posedge o_clk) begin
      logic [3*W-1:0] e;
      #1;
      if (!o_rst && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("mon_sync_o", 32'(sync_o), 32'(e[3*W-1:2*W]));
         check("mon_rise_o", 32'(rise_o), 32'(e[2*W-1:W]));
         check("mon_fall_o", 32'(fall_o), 32'(e[W-1:0]));
         check("mon_rise_and_fall", 32'(rise_o & fall_o), 32'h0);
      end
   end

   initial begin
      int lat;
      logic [W-1:0] v;
      o_rst    = 1'b1;
      sync_i   = '0;
      filt_thr = '0;
      #2;
      check("init_sync_o", 32'(sync_o), 32'(RV));
      check("init_rise_o", 32'(rise_o), 32'h0);
      check("init_fall_o", 32'(fall_o), 32'h0);
      @(negedge o_clk);
      @(negedge o_clk);
      o_rst = 1'b0;
      model_reset();

      // T=2, channel 0 rises and holds: appears D+T+1 edges after sampling.
      filt_thr = 3'd2;
      hold(4'h0, 12);
      lat = D + (FILT_ON ? 2 : 0) + 1;
      hold(4'h1, lat - 1);
      check("lat_pre_sync0", 32'(sync_o[0]), 32'h0);
      step(4'h1);
      check("lat_sync0", 32'(sync_o[0]), 32'h1);
      check("lat_rise0", 32'(rise_o[0]), 32'h1);
      step(4'h1);
      check("lat_rise0_once", 32'(rise_o[0]), 32'h0);
      check("lat_sync0_hold", 32'(sync_o[0]), 32'h1);

      // T=3, short pulse on channel 1 is rejected by the filter.
      filt_thr = 3'd3;
      hold(4'h0, 12);
      hold(4'h2, 2);
      hold(4'h0, 12);
      check("glitch_sync1_end", 32'(sync_o[1]), 32'h0);

      // T=0, all channels follow at D+1 with one-cycle pulses.
      filt_thr = 3'd0;
      hold(4'hF, D + 1);
      check("t0_sync_hi", 32'(sync_o), 32'hF);
      check("t0_rise", 32'(rise_o), 32'hF);
      step(4'hF);
      check("t0_rise_once", 32'(rise_o), 32'h0);
      hold(4'h0, D + 1);
      check("t0_sync_lo", 32'(sync_o), 32'h0);
      check("t0_fall", 32'(fall_o), 32'hF);
      step(4'h0);
      check("t0_fall_once", 32'(fall_o), 32'h0);

      // Reset mid-count with inputs at 5, then recovery without release pulse.
      filt_thr = 3'd2;
      hold(4'h5, D + 2);
      do_reset();
      lat = D + (FILT_ON ? 2 : 0) + 1;
      hold(4'h5, lat - 1);
      check("rel_sync_pre", 32'(sync_o), 32'(RV));
      step(4'h5);
      check("rel_sync", 32'(sync_o), 32'h5);
      check("rel_rise", 32'(rise_o), 32'h5);
      check("rel_fall", 32'(fall_o), 32'hA);

      // T lowered 7 -> 1 while the count stands at 4.
      filt_thr = 3'd7;
      hold(4'h0, 16);
      hold(4'hF, D + 4);
      check("thr_drop_pre", 32'(sync_o), FILT_ON ? 32'h0 : 32'hF);
      filt_thr = 3'd1;
      step(4'hF);
      check("thr_drop_post", 32'(sync_o), 32'hF);

      // T=7, single-cycle glitch: passes only when filtering is absent.
      filt_thr = 3'd7;
      hold(4'h0, 16);
      step(4'hF);
      hold(4'h0, D);
      check("glitch7", 32'(sync_o), FILT_ON ? 32'h0 : 32'hF);
      hold(4'h0, 16);

      // Randomised blocks: random threshold, toggle density and resets.
      for (int blk = 0; blk < 12; blk++) begin
         int p;
         filt_thr = FW'($urandom_range(0, 7));
         p = $urandom_range(1, 8);
         if ($urandom_range(0, 3) == 0) do_reset();
         for (int n = 0; n < 40; n++) begin
            v = sync_i;
            for (int c = 0; c < W; c++) begin
               if ($urandom_range(0, 15) < p) v[c] = ~v[c];
            end
            step(v);
         end
      end

      hold(sync_i, 4);
      check("queue_drained", 32'(exp_q.size()), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/nv_nvdla_ssyncnd_c.md
NV_NVDLA_SSYNCND_C -- requirements
Module: nv_nvdla_ssyncnd_c

Interface
REQ-001 Parameter WIDTH, default 4, channel count (1..32).
REQ-002 Parameter DEPTH, default 3, synchroniser flop stages per channel (2..4).
REQ-003 Parameter FILT_W, default 3, filter counter and threshold width (1..8).
REQ-004 Parameter RESET_VAL, default {WIDTH{1'b0}}, per-channel reset value of all state.
REQ-005 o_clk  input  1  sole clock; all state on rising edge.
REQ-006 o_rst  input  1  asynchronous, active-high reset.
REQ-007 sync_i  input  WIDTH  asynchronous level inputs, one per channel.
REQ-008 filt_thr  input  FILT_W  quasi-static filter threshold T, in cycles.
REQ-009 sync_o  output  WIDTH  synchronised, filtered levels, registered.
REQ-010 rise_o  output  WIDTH  one-cycle pulse per channel on sync_o 0->1, registered.
REQ-011 fall_o  output  WIDTH  one-cycle pulse per channel on sync_o 1->0, registered.

Function
REQ-012 Each channel SHALL pass sync_i through a DEPTH-flop chain; last stage is q.
REQ-013 Each channel SHALL hold a saturating FILT_W-bit counter cnt; it never wraps.
REQ-014 Per edge: if q==sync_o then cnt<=0; elsif cnt>=T then sync_o<=q, cnt<=0; else cnt<=cnt+1.
REQ-015 A stable input change SHALL reach sync_o exactly DEPTH+T+1 edges after the first sampling edge.
REQ-016 A q excursion shorter than T+1 cycles SHALL clear cnt and leave sync_o unchanged.
REQ-017 T=0 SHALL give latency DEPTH+1 with no filtering.
REQ-018 filt_thr changes SHALL apply at the next compare; cnt>=new T updates sync_o on that edge.
REQ-019 rise_o/fall_o SHALL assert in the same cycle sync_o takes its new value, for exactly one cycle.
REQ-020 rise_o and fall_o of one channel SHALL never assert together; channels are independent.

Reset
REQ-021 o_rst high SHALL immediately force all chain flops and sync_o to RESET_VAL, cnt to 0, rise_o/fall_o to 0.
REQ-022 Reset release SHALL produce no pulse; a differing input is treated as a new change from release.
REQ-023 Reset mid-filter SHALL discard the partial count.

Configuration
REQ-024 Macro NVDLA_SSYNC_FILTER_EN defined: counters and filt_thr behave per REQ-013..018.
REQ-025 Macro undefined: no counters; sync_o<=q every edge (latency DEPTH+1); filt_thr is ignored; pulses retained.

Structure
REQ-026 Shared package/include SHALL hold DEPTH/FILT_W legal ranges and the RESET_VAL default constant.
REQ-027 Per-channel filter+edge logic SHALL be sub-module nv_nvdla_ssync_filt, instantiated WIDTH times by generate.
REQ-028 Chain flops SHALL be named-stage flops, kept separate from filter logic, for CDC tool recognition.

Verification
REQ-029 DEPTH=3, T=2, sync_i[0] 0->1 held -> sync_o[0]=1 and rise_o[0]=1 six edges later, for one cycle.
REQ-030 T=3, sync_i[1] high for 2 cycles then low -> sync_o[1] stays 0; no pulses.
REQ-031 T=0, sync_i=4'hF then 4'h0 -> sync_o follows at DEPTH+1; rise_o=4'hF then fall_o=4'hF, one cycle each.
REQ-032 RESET_VAL=4'hA, o_rst pulsed mid-count with sync_i=4'h5 -> sync_o=4'hA at once, no pulse on release, 4'h5 after DEPTH+T+1.
REQ-033 T lowered 7->1 with cnt=4 -> sync_o updates on next edge.
REQ-034 Macro undefined, filt_thr=7 -> latency DEPTH+1; 1-cycle glitch propagates.
